// File: rtl/key_debounce.sv
// key_debounce: multi-channel key/switch debouncer.
// Each raw key level is brought into the clk domain by a 2-flop synchronizer,
// then qualified by a per-channel FSM that accepts a level change only after
// STABLE consecutive tick-qualified samples agree on the new level.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   tick         sample-enable strobe (may be held high continuously)
//   key_in       raw asynchronous key levels, 1 = pressed
//   key_level    debounced key levels (registered)
//   key_press    1-clk pulse on an accepted 0->1 change (registered)
//   key_release  1-clk pulse on an accepted 1->0 change (registered)
module key_debounce #(
    parameter int unsigned NKEY   = 5,
    parameter int unsigned STABLE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [NKEY-1:0] key_in,
    output logic [NKEY-1:0] key_level,
    output logic [NKEY-1:0] key_press,
    output logic [NKEY-1:0] key_release
);

    localparam int unsigned CNT_W = $clog2(STABLE + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        DOWN,
        RELEASE_WAIT
    } state_e;

    logic [NKEY-1:0] sync1_q;
    logic [NKEY-1:0] sync2_q;

    // Synchronizer runs every clk, independent of tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NKEY; g++) begin : g_chan
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             sync;

        assign sync = sync2_q[g];

        // Next-state / output logic; nothing but the pulses moves without tick.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        if (sync) begin
                            state_d = PRESS_WAIT;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            cnt_d   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_W'(STABLE - 1)) begin
                            state_d = DOWN;
                            cnt_d   = '0;
                            level_d = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                    DOWN: begin
                        if (!sync) begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            cnt_d   = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync) begin
                            state_d = DOWN;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_W'(STABLE - 1)) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d     = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // Per-channel state register; reset wins over tick.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign key_level[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
    end

endmodule
